// File: rtl/ps2_key_event_fifo.sv
// rtl/ps2_key_event_fifo.sv - PS/2 Set-2 scancode decoder with held-key table, modifiers and event FIFO
module ps2_key_event_fifo #(
    parameter int DEPTH           = 16,
    parameter int CNT_W           = 8,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                     CLK100MHZ,
    input  logic                     BTNC,
    input  logic [7:0]               code_in,
    input  logic                     code_valid,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [10:0]              ev_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         key_count,
    output logic [7:0]               last_code,
    output logic [7:0]               prev_code,
    output logic [4:0]               mods
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

    state_t        state;
    logic [2:0]    skip_cnt;
    logic          cv_q;
    logic          acc_q;
    logic [7:0]    byte_q;
    logic [511:0]  held;
    logic          caps_lock;
    logic          num_lock;
    logic          ev_pend;
    logic [10:0]   ev_word;

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          dec_make;
    logic          dec_brk;
    logic          dec_ext;
    logic          is_prefix;
    logic          is_ignored;
    logic [8:0]    idx;
    logic          fresh;
    logic          rpt;
    logic          full;
    logic          do_pop;
    logic          do_wr;

    // Stage 1: edge-detect code_valid and capture the byte. The edge register
    // follows code_valid during reset so a level already high at release is not taken.
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            cv_q   <= code_valid;
            acc_q  <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            cv_q   <= code_valid;
            acc_q  <= code_valid & ~cv_q;
            byte_q <= code_in;
        end
    end

    // Classify the captured byte against the current prefix state
    always_comb begin
        dec_make   = 1'b0;
        dec_brk    = 1'b0;
        dec_ext    = 1'b0;
        is_prefix  = (byte_q == 8'hE0) || (byte_q == 8'hF0) || (byte_q == 8'hE1);
        is_ignored = (byte_q == 8'h00) || (byte_q == 8'hAA) || (byte_q == 8'hFA) ||
                     (byte_q == 8'hFE) || (byte_q == 8'hFF);
        if (acc_q) begin
            case (state)
                S_IDLE:   dec_make = !is_prefix && !is_ignored;
                S_EXT:    begin dec_make = !is_prefix; dec_ext = 1'b1; end
                S_BRK:    dec_brk  = !is_prefix;
                S_EXTBRK: begin dec_brk = !is_prefix; dec_ext = 1'b1; end
                default:  ;
            endcase
        end
    end

    assign idx   = {dec_ext, byte_q};
    assign fresh = dec_make & ~held[idx];
    assign rpt   = dec_make &  held[idx];

    // Prefix FSM: one transition per accepted byte; Pause swallows the next 7 bytes
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            state    <= S_IDLE;
            skip_cnt <= 3'd0;
        end else if (acc_q) begin
            case (state)
                S_IDLE: begin
                    if (byte_q == 8'hE0) state <= S_EXT;
                    else if (byte_q == 8'hF0) state <= S_BRK;
                    else if (byte_q == 8'hE1) begin
                        state    <= S_SKIP;
                        skip_cnt <= 3'd7;
                    end
                end
                S_EXT:   state <= (byte_q == 8'hF0) ? S_EXTBRK : S_IDLE;
                S_SKIP: begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage 2: held table, counters, lock toggles and the pending event word
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            held      <= '0;
            key_count <= '0;
            last_code <= 8'h00;
            prev_code <= 8'h00;
            caps_lock <= 1'b0;
            num_lock  <= 1'b0;
            ev_pend   <= 1'b0;
            ev_word   <= 11'h000;
        end else begin
            ev_pend <= 1'b0;
            if (fresh) begin
                held[idx] <= 1'b1;
                key_count <= key_count + 1'b1;
                prev_code <= last_code;
                last_code <= byte_q;
                if (idx == 9'h058) caps_lock <= ~caps_lock;
                if (idx == 9'h077) num_lock  <= ~num_lock;
                ev_pend   <= 1'b1;
                ev_word   <= {1'b0, dec_ext, 1'b0, byte_q};
            end
            if (rpt && SUPPRESS_REPEAT == 0) begin
                ev_pend <= 1'b1;
                ev_word <= {1'b1, dec_ext, 1'b0, byte_q};
            end
            if (dec_brk) begin
                held[idx] <= 1'b0;
                ev_pend   <= 1'b1;
                ev_word   <= {1'b0, dec_ext, 1'b1, byte_q};
            end
        end
    end

    assign mods = {caps_lock, num_lock,
                   held[9'h014] | held[9'h114],
                   held[9'h011] | held[9'h111],
                   held[9'h012] | held[9'h059]};

    assign full     = (fifo_level == DEPTH[AW:0]);
    assign ev_valid = (fifo_level != '0);
    assign do_pop   = ev_valid & ev_ready;
    assign do_wr    = ev_pend & (~full | do_pop);
    assign ev_data  = ev_valid ? mem[rd_ptr] : 11'h000;

    // FIFO storage; contents are masked by ev_valid so no reset is needed here
    always_ff @(posedge CLK100MHZ) begin
        if (do_wr) mem[wr_ptr] <= ev_word;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
            if (ev_pend && !do_wr) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// tb/tb_ps2_key_event_fifo.sv - directed self-checking bench for ps2_key_event_fifo
module tb_ps2_key_event_fifo;

    logic        clk;
    int          tests;
    int          fails;

    logic        a_btn, a_cv, a_rdy, a_evv, a_ovf;
    logic [7:0]  a_code, a_last, a_prev, a_key;
    logic [10:0] a_data;
    logic [4:0]  a_lvl, a_mods;

    logic        b_btn, b_cv, b_rdy, b_evv, b_ovf;
    logic [7:0]  b_code, b_last, b_prev, b_key;
    logic [10:0] b_data;
    logic [2:0]  b_lvl;
    logic [4:0]  b_mods;

    ps2_key_event_fifo #(.DEPTH(16), .CNT_W(8), .SUPPRESS_REPEAT(1)) dut_a (
        .CLK100MHZ(clk), .BTNC(a_btn), .code_in(a_code), .code_valid(a_cv),
        .ev_valid(a_evv), .ev_ready(a_rdy), .ev_data(a_data), .fifo_level(a_lvl),
        .overflow(a_ovf), .key_count(a_key), .last_code(a_last), .prev_code(a_prev),
        .mods(a_mods)
    );

    ps2_key_event_fifo #(.DEPTH(4), .CNT_W(8), .SUPPRESS_REPEAT(0)) dut_b (
        .CLK100MHZ(clk), .BTNC(b_btn), .code_in(b_code), .code_valid(b_cv),
        .ev_valid(b_evv), .ev_ready(b_rdy), .ev_data(b_data), .fifo_level(b_lvl),
        .overflow(b_ovf), .key_count(b_key), .last_code(b_last), .prev_code(b_prev),
        .mods(b_mods)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] b);
        @(negedge clk);
        if (sel == 0) begin a_code = b; a_cv = 1'b1; end
        else          begin b_code = b; b_cv = 1'b1; end
        @(negedge clk);
        a_cv = 1'b0;
        b_cv = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pop_check(input int sel, input string tag, input logic [10:0] exp);
        int n;
        n = 0;
        while (!(sel == 0 ? a_evv : b_evv) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, sel == 0 ? a_data : b_data, exp);
        if (sel == 0) a_rdy = 1'b1; else b_rdy = 1'b1;
        @(negedge clk);
        a_rdy = 1'b0;
        b_rdy = 1'b0;
    endtask

    task automatic do_reset(input int sel);
        @(negedge clk);
        if (sel == 0) a_btn = 1'b1; else b_btn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_btn = 1'b0;
        b_btn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0;
        a_btn = 1'b1; a_cv = 1'b1; a_rdy = 1'b0; a_code = 8'h1C;
        b_btn = 1'b1; b_cv = 1'b0; b_rdy = 1'b0; b_code = 8'h00;
        repeat (3) @(negedge clk);
        a_btn = 1'b0; b_btn = 1'b0;
        repeat (5) @(negedge clk);

        // reset state, with code_valid already high at release
        check("rst_level", a_lvl, 0);
        check("rst_valid", a_evv, 0);
        check("rst_data", a_data, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_key", a_key, 0);
        check("rst_last", a_last, 0);
        check("rst_prev", a_prev, 0);
        check("rst_mods", a_mods, 0);
        a_cv = 1'b0;
        @(negedge clk);

        // latency: accept edge k, ev_valid only after k+2; level held high -> one byte
        a_code = 8'h1C; a_cv = 1'b1;
        @(negedge clk);
        check("lat_k", a_evv, 0);
        @(negedge clk);
        check("lat_k1", a_evv, 0);
        a_cv = 1'b0;
        @(negedge clk);
        check("lat_k2", a_evv, 1);
        repeat (3) @(negedge clk);
        check("hold_one", a_lvl, 1);
        send(0, 8'hF0); send(0, 8'h1C);
        pop_check(0, "mk_1c", 11'h01C);
        pop_check(0, "bk_1c", 11'h11C);
        check("key1", a_key, 1);
        check("last1", a_last, 8'h1C);
        send(0, 8'h1C);
        pop_check(0, "mk_1c_again", 11'h01C);
        check("key2", a_key, 2);
        check("prev2", a_prev, 8'h1C);
        send(0, 8'hF0); send(0, 8'h1C);
        pop_check(0, "bk_1c_again", 11'h11C);

        // extended make / break
        send(0, 8'hE0); send(0, 8'h75);
        send(0, 8'hE0); send(0, 8'hF0); send(0, 8'h75);
        pop_check(0, "ext_mk", 11'h275);
        pop_check(0, "ext_bk", 11'h375);
        check("ext_mods", a_mods, 0);
        check("key3", a_key, 3);

        // typematic repeat suppressed
        send(0, 8'h1C); send(0, 8'h1C); send(0, 8'h1C);
        send(0, 8'hF0); send(0, 8'h1C);
        check("sup_level", a_lvl, 2);
        check("sup_key", a_key, 4);
        pop_check(0, "sup_mk", 11'h01C);
        pop_check(0, "sup_bk", 11'h11C);

        // modifiers and locks
        send(0, 8'h12);
        check("mods_shift", a_mods, 5'h01);
        send(0, 8'h58);
        check("mods_caps", a_mods, 5'h11);
        send(0, 8'hF0); send(0, 8'h58);
        check("mods_caps_rel", a_mods, 5'h11);
        send(0, 8'hF0); send(0, 8'h12);
        check("mods_unshift", a_mods, 5'h10);
        send(0, 8'hE0); send(0, 8'h14);
        check("mods_ctrl", a_mods, 5'h14);
        check("mods_level", a_lvl, 5);
        pop_check(0, "ev_12", 11'h012);
        pop_check(0, "ev_58", 11'h058);
        pop_check(0, "ev_b58", 11'h158);
        pop_check(0, "ev_b12", 11'h112);
        pop_check(0, "ev_e14", 11'h214);
        check("key7", a_key, 7);
        check("last14", a_last, 8'h14);
        check("prev58", a_prev, 8'h58);

        // ev_ready while empty is ignored; Pause sequence is discarded
        @(negedge clk); a_rdy = 1'b1;
        @(negedge clk); a_rdy = 1'b0;
        send(0, 8'hE1); send(0, 8'h14); send(0, 8'h77); send(0, 8'hE1);
        send(0, 8'hF0); send(0, 8'h14); send(0, 8'hF0); send(0, 8'h77);
        check("pause_level", a_lvl, 0);
        check("pause_mods", a_mods, 5'h14);
        check("pause_key", a_key, 7);
        send(0, 8'h1C);
        pop_check(0, "pause_next", 11'h01C);
        check("key8", a_key, 8);

        // reset after a lone E0 prefix
        send(0, 8'hE0);
        do_reset(0);
        check("mid_rst_key", a_key, 0);
        check("mid_rst_mods", a_mods, 0);
        send(0, 8'h75);
        pop_check(0, "mid_rst_ev", 11'h075);

        // repeats queued with rep=1
        send(1, 8'h1C); send(1, 8'h1C); send(1, 8'h1C);
        send(1, 8'hF0); send(1, 8'h1C);
        check("rep_level", b_lvl, 4);
        check("rep_key", b_key, 1);
        check("rep_ovf", b_ovf, 0);
        pop_check(1, "rep_e0", 11'h01C);
        pop_check(1, "rep_e1", 11'h41C);
        pop_check(1, "rep_e2", 11'h41C);
        pop_check(1, "rep_e3", 11'h11C);

        // overflow on a 4-deep FIFO
        do_reset(1);
        send(1, 8'h15); send(1, 8'h1D); send(1, 8'h24);
        send(1, 8'h2D); send(1, 8'h2C); send(1, 8'h35);
        check("ovf_level", b_lvl, 4);
        check("ovf_flag", b_ovf, 1);
        check("ovf_key", b_key, 6);
        check("ovf_last", b_last, 8'h35);
        check("ovf_prev", b_prev, 8'h2C);

        // pop coinciding with the write of a new make while full
        @(negedge clk); b_code = 8'h3C; b_cv = 1'b1;
        @(negedge clk); b_cv = 1'b0;
        @(negedge clk); b_rdy = 1'b1;
        @(negedge clk); b_rdy = 1'b0;
        check("full_rw_level", b_lvl, 4);
        check("full_rw_ovf", b_ovf, 1);
        check("full_rw_key", b_key, 7);
        pop_check(1, "full_e0", 11'h01D);
        pop_check(1, "full_e1", 11'h024);
        pop_check(1, "full_e2", 11'h02D);
        pop_check(1, "full_e3", 11'h03C);
        check("full_empty", b_lvl, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
